qqspi_arbiter: RTL and testbench

- Two-master round-robin arbiter in front of the shared qqspi memory controller, which serves both SPI NOR flash and PSRAM.
- Master 0 is the CPU memory port. Master 1 is a second bus master, e.g. a DMA or framebuffer fetch engine.
- Each master's request is latched at grant and presented to qqspi as one stable transaction, so a master that misbehaves cannot disturb an access already in flight.
- Generates the qqspi valid, chip-select control and PSRAM/flash select signals.

---
 rtl/qqspi_arbiter.sv | 142 ++++++++++++++
 tb/tb_qqspi_arbiter.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/qqspi_arbiter.sv
// Two-master round-robin arbiter in front of the shared qqspi flash/PSRAM controller.
// Define QQSPI_ARB_REG_RDATA_EN to register read data and delay master ready by one cycle.
module qqspi_arbiter #(
  parameter int ADDR_W = 23,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                m0_valid,
  output logic                m0_ready,
  input  logic [ADDR_W-1:0]   m0_addr,
  input  logic [DATA_W-1:0]   m0_wdata,
  input  logic [DATA_W/8-1:0] m0_wstrb,
  input  logic                m0_psram,
  output logic [DATA_W-1:0]   m0_rdata,
  input  logic                m1_valid,
  output logic                m1_ready,
  input  logic [ADDR_W-1:0]   m1_addr,
  input  logic [DATA_W-1:0]   m1_wdata,
  input  logic [DATA_W/8-1:0] m1_wstrb,
  input  logic                m1_psram,
  output logic [DATA_W-1:0]   m1_rdata,
  output logic                s_valid,
  input  logic                s_ready,
  output logic [ADDR_W-1:0]   s_addr,
  output logic [DATA_W-1:0]   s_wdata,
  output logic [DATA_W/8-1:0] s_wstrb,
  output logic                s_psram,
  output logic [2:0]          s_ce_ctrl,
  input  logic [DATA_W-1:0]   s_rdata,
  output logic                busy,
  output logic                owner
);

  localparam int STRB_W = DATA_W / 8;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_BUSY    = 2'd1,
    ST_RELEASE = 2'd2,
    ST_RESP    = 2'd3
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic                r_ptr;
  logic                r_owner;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic [STRB_W-1:0]   r_wstrb;
  logic                r_psram;
  logic [DATA_W-1:0]   r_m0_rdata;
  logic [DATA_W-1:0]   r_m1_rdata;
  logic                w_grant;
  logic                w_gnt_idx;
  logic                w_done;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_state <= ST_IDLE;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_grant     = 1'b0;
    w_gnt_idx   = r_ptr;
    w_done      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (m0_valid || m1_valid) begin
          w_grant     = 1'b1;
          // Pointer only breaks ties; a lone requester always wins.
          w_gnt_idx   = (m0_valid && m1_valid) ? r_ptr : m1_valid;
          w_state_nxt = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (s_ready) begin
          w_done = 1'b1;
`ifdef QQSPI_ARB_REG_RDATA_EN
          w_state_nxt = ST_RESP;
`else
          w_state_nxt = ST_RELEASE;
`endif
        end
      end
      ST_RESP:    w_state_nxt = ST_RELEASE;
      ST_RELEASE: w_state_nxt = ST_IDLE;
      default:    w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_ptr      <= 1'b0;
      r_owner    <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_wstrb    <= '0;
      r_psram    <= 1'b0;
      r_m0_rdata <= '0;
      r_m1_rdata <= '0;
    end else begin
      if (w_grant) begin
        r_owner <= w_gnt_idx;
        r_addr  <= w_gnt_idx ? m1_addr  : m0_addr;
        r_wdata <= w_gnt_idx ? m1_wdata : m0_wdata;
        r_wstrb <= w_gnt_idx ? m1_wstrb : m0_wstrb;
        r_psram <= w_gnt_idx ? m1_psram : m0_psram;
      end
      if (w_done) begin
        r_ptr <= ~r_owner;
        if (r_owner) r_m1_rdata <= s_rdata;
        else         r_m0_rdata <= s_rdata;
      end
    end
  end

  // Bus side is driven only from the latched copy, never from live master inputs.
  assign s_valid   = (r_state == ST_BUSY);
  assign s_addr    = r_addr;
  assign s_wdata   = r_wdata;
  assign s_wstrb   = r_wstrb;
  assign s_psram   = r_psram;
  assign s_ce_ctrl = {1'b0, s_valid & r_psram, s_valid & ~r_psram};
  assign owner     = r_owner;

`ifdef QQSPI_ARB_REG_RDATA_EN
  assign busy     = (r_state == ST_BUSY) || (r_state == ST_RESP);
  assign m0_ready = (r_state == ST_RESP) & ~r_owner;
  assign m1_ready = (r_state == ST_RESP) &  r_owner;
  assign m0_rdata = r_m0_rdata;
  assign m1_rdata = r_m1_rdata;
`else
  assign busy     = (r_state == ST_BUSY);
  assign m0_ready = w_done & ~r_owner;
  assign m1_ready = w_done &  r_owner;
  assign m0_rdata = m0_ready ? s_rdata : r_m0_rdata;
  assign m1_rdata = m1_ready ? s_rdata : r_m1_rdata;
`endif

endmodule

// File: tb/tb_qqspi_arbiter.sv
// Scoreboard bench for qqspi_arbiter: expected grants queued at request time, checked on the bus.
module tb_qqspi_arbiter;

  localparam int ADDR_W = 23;
  localparam int DATA_W = 32;
  localparam int STRB_W = 4;
`ifdef QQSPI_ARB_REG_RDATA_EN
  localparam int GAP = 3;
`else
  localparam int GAP = 2;
`endif

  logic              clk = 1'b0;
  logic              resetn;
  logic              m0_valid, m0_ready, m0_psram;
  logic [ADDR_W-1:0] m0_addr;
  logic [DATA_W-1:0] m0_wdata, m0_rdata;
  logic [STRB_W-1:0] m0_wstrb;
  logic              m1_valid, m1_ready, m1_psram;
  logic [ADDR_W-1:0] m1_addr;
  logic [DATA_W-1:0] m1_wdata, m1_rdata;
  logic [STRB_W-1:0] m1_wstrb;
  logic              s_valid, s_ready, s_psram, busy, owner;
  logic [ADDR_W-1:0] s_addr;
  logic [DATA_W-1:0] s_wdata, s_rdata;
  logic [STRB_W-1:0] s_wstrb;
  logic [2:0]        s_ce_ctrl;

  qqspi_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .resetn(resetn),
    .m0_valid(m0_valid), .m0_ready(m0_ready), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_wstrb(m0_wstrb), .m0_psram(m0_psram), .m0_rdata(m0_rdata),
    .m1_valid(m1_valid), .m1_ready(m1_ready), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_wstrb(m1_wstrb), .m1_psram(m1_psram), .m1_rdata(m1_rdata),
    .s_valid(s_valid), .s_ready(s_ready), .s_addr(s_addr), .s_wdata(s_wdata),
    .s_wstrb(s_wstrb), .s_psram(s_psram), .s_ce_ctrl(s_ce_ctrl), .s_rdata(s_rdata),
    .busy(busy), .owner(owner)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic              own;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [STRB_W-1:0] wstrb;
    logic              psram;
    logic [DATA_W-1:0] rdata;
  } txn_t;

  txn_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   last_rdy_cyc = 0;
  int   k0, k1;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic own, input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] wdata,
                      input logic [STRB_W-1:0] wstrb, input logic psram, input logic [DATA_W-1:0] rdata);
    txn_t t;
    t.own = own; t.addr = addr; t.wdata = wdata; t.wstrb = wstrb; t.psram = psram; t.rdata = rdata;
    exp_q.push_back(t);
  endtask

  // Acts as qqspi: waits for s_valid, checks the latched request, answers after lat cycles.
  task automatic serve(input int lat, input bit chk_gap, input bit perturb);
    txn_t t;
    int   n;
    n = 0;
    while (!s_valid && n < 20) begin
      tick();
      n++;
    end
    if (!s_valid) begin
      check_eq("svalid_timeout", 64'd0, 64'd1);
      return;
    end
    if (exp_q.size() == 0) begin
      check_eq("sb_empty", 64'd0, 64'd1);
      return;
    end
    t = exp_q.pop_front();
    if (chk_gap) check_eq("gap", 64'(cyc - last_rdy_cyc), 64'(GAP + 1));
    check_eq("owner", owner, t.own);
    check_eq("s_addr", s_addr, t.addr);
    check_eq("s_wdata", s_wdata, t.wdata);
    check_eq("s_wstrb", s_wstrb, t.wstrb);
    check_eq("s_psram", s_psram, t.psram);
    check_eq("ce_ctrl", s_ce_ctrl, {1'b0, t.psram, ~t.psram});
    check_eq("busy", busy, 1'b1);
    for (int i = 0; i < lat; i++) begin
      if (perturb) begin
        m0_valid = 1'b0;
        m0_addr  = ADDR_W'($urandom);
      end
      tick();
      check_eq("hold_valid", s_valid, 1'b1);
      check_eq("hold_addr", s_addr, t.addr);
    end
    s_ready = 1'b1;
    s_rdata = t.rdata;
    last_rdy_cyc = cyc;
`ifdef QQSPI_ARB_REG_RDATA_EN
    #1;
    check_eq("early_rdy", m0_ready | m1_ready, 1'b0);
    tick();
    s_ready = 1'b0;
    s_rdata = $urandom;
    #1;
    check_eq("svalid_drop", s_valid, 1'b0);
`else
    #1;
`endif
    check_eq("rdy_own", t.own ? m1_ready : m0_ready, 1'b1);
    check_eq("rdy_other", t.own ? m0_ready : m1_ready, 1'b0);
    check_eq("rdata", t.own ? m1_rdata : m0_rdata, t.rdata);
    tick();
    s_ready = 1'b0;
    s_rdata = $urandom;
    #1;
    check_eq("rdy_pulse", m0_ready | m1_ready, 1'b0);
    check_eq("rdata_hold", t.own ? m1_rdata : m0_rdata, t.rdata);
    check_eq("release_valid", s_valid, 1'b0);
  endtask

  initial begin
    resetn = 1'b0;
    s_ready = 1'b0; s_rdata = '0;
    m0_valid = 1'b0; m0_addr = '0; m0_wdata = '0; m0_wstrb = '0; m0_psram = 1'b0;
    m1_valid = 1'b0; m1_addr = '0; m1_wdata = '0; m1_wstrb = '0; m1_psram = 1'b0;
    repeat (3) tick();
    check_eq("rst_svalid", s_valid, 1'b0);
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_owner", owner, 1'b0);
    check_eq("rst_ready", {m0_ready, m1_ready}, 2'b00);
    check_eq("rst_ce", s_ce_ctrl, 3'b000);
    check_eq("rst_addr", s_addr, '0);
    check_eq("rst_rdata", {m0_rdata, m1_rdata}, '0);
    resetn = 1'b1;
    tick();

    // Simultaneous requests straight after reset: m0 first, then m1.
    m0_valid = 1'b1; m0_addr = 23'h10;
    m1_valid = 1'b1; m1_addr = 23'h20;
    push(1'b0, 23'h10, '0, '0, 1'b0, 32'hA0A0_0001);
    push(1'b1, 23'h20, '0, '0, 1'b0, 32'hB0B0_0002);
    serve(1, 1'b0, 1'b0);
    m0_valid = 1'b0;
    serve(2, 1'b1, 1'b0);
    m1_valid = 1'b0;

    // Continuous contention: six grants, strictly alternating.
    k0 = 0; k1 = 0;
    m0_valid = 1'b1; m0_addr = 23'h100; m0_wstrb = 4'h0; m0_wdata = 32'h0;
    m1_valid = 1'b1; m1_addr = 23'h200; m1_wstrb = 4'h3; m1_wdata = 32'hC0DE_0000;
    for (int i = 0; i < 3; i++) begin
      push(1'b0, 23'h100 + 23'(i), 32'h0, 4'h0, 1'b0, 32'h1000_0000 + 32'(i));
      push(1'b1, 23'h200 + 23'(i), 32'hC0DE_0000 + 32'(i), 4'h3, 1'b0, 32'h2000_0000 + 32'(i));
    end
    for (int i = 0; i < 6; i++) begin
      serve(1 + (i % 3), 1'b1, 1'b0);
      if (i % 2 == 0) begin
        k0++;
        if (k0 < 3) m0_addr = 23'h100 + 23'(k0);
        else        m0_valid = 1'b0;
      end else begin
        k1++;
        if (k1 < 3) begin
          m1_addr  = 23'h200 + 23'(k1);
          m1_wdata = 32'hC0DE_0000 + 32'(k1);
        end else begin
          m1_valid = 1'b0;
        end
      end
    end

    // Single flash read from m0 with one-cycle request latency.
    tick(); tick();
    m0_valid = 1'b1; m0_addr = 23'h000100; m0_wstrb = 4'h0; m0_psram = 1'b0;
    push(1'b0, 23'h000100, m0_wdata, 4'h0, 1'b0, 32'hDEADBEEF);
    tick();
    check_eq("req_latency", s_valid, 1'b1);
    check_eq("ce_flash", s_ce_ctrl, 3'b001);
    serve(3, 1'b0, 1'b0);
    m0_valid = 1'b0;

    // PSRAM write from m1.
    m1_valid = 1'b1; m1_addr = 23'h004000; m1_wdata = 32'h12345678; m1_wstrb = 4'hF; m1_psram = 1'b1;
    push(1'b1, 23'h004000, 32'h12345678, 4'hF, 1'b1, 32'h0BAD_F00D);
    serve(0, 1'b0, 1'b0);
    m1_valid = 1'b0; m1_psram = 1'b0;

    // m0 misbehaves during BUSY: drops valid and scrambles its address.
    m0_valid = 1'b1; m0_addr = 23'h777; m0_wdata = 32'hFACE_CAFE; m0_wstrb = 4'h1;
    push(1'b0, 23'h777, 32'hFACE_CAFE, 4'h1, 1'b0, 32'h7777_7777);
    serve(4, 1'b0, 1'b1);
    m0_valid = 1'b0;

    // Stray s_ready while idle must not reach either master.
    tick(); tick();
    s_ready = 1'b1; s_rdata = 32'h5555_5555;
    #1;
    check_eq("idle_rdy", {m0_ready, m1_ready}, 2'b00);
    check_eq("idle_rdata", m1_rdata, 32'h0BAD_F00D);
    tick();
    s_ready = 1'b0;
    tick();
    check_eq("idle_svalid", s_valid, 1'b0);
    check_eq("idle_busy", busy, 1'b0);

    // Asynchronous reset in the middle of an access.
    m0_valid = 1'b1; m0_addr = 23'h55; m0_wstrb = 4'h0;
    tick();
    check_eq("pre_rst_valid", s_valid, 1'b1);
    s_ready = 1'b1; s_rdata = 32'h9999_9999;
    resetn = 1'b0;
    #1;
    check_eq("arst_svalid", s_valid, 1'b0);
    check_eq("arst_busy", busy, 1'b0);
    check_eq("arst_ready", {m0_ready, m1_ready}, 2'b00);
    check_eq("arst_owner", owner, 1'b0);
    check_eq("arst_addr", s_addr, '0);
    check_eq("arst_rdata", m0_rdata, '0);
    s_ready = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    m0_addr = 23'h66;
    push(1'b0, 23'h66, m0_wdata, 4'h0, 1'b0, 32'h6666_0066);
    serve(1, 1'b0, 1'b0);
    m0_valid = 1'b0;
    tick();
    check_eq("sb_drained", 64'(exp_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
